// File: rtl/lz77_decoder_if.sv
// Token/character bus between the LZ77 token source and lz77_decoder.
// LZ77_DEC_ERR_EN adds the sticky err output.
interface lz77_decoder_if;
    logic       valid;
    logic       encode;
    logic [4:0] offset;
    logic [4:0] match_len;
    logic [7:0] char_nxt;
    logic       ready;
    logic       out_valid;
    logic [7:0] out_char;
    logic       finish;
`ifdef LZ77_DEC_ERR_EN
    logic       err;
`endif

    modport master (
        output valid, encode, offset, match_len, char_nxt,
        input  ready, out_valid, out_char, finish
`ifdef LZ77_DEC_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  valid, encode, offset, match_len, char_nxt,
        output ready, out_valid, out_char, finish
`ifdef LZ77_DEC_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: rebuilds the character stream from (offset, match_len, char_nxt)
// tokens using a shift-window history. Optional LZ77_DEC_ERR_EN adds a sticky err flag.
module lz77_decoder #(
    parameter int unsigned WIN_DEPTH = 30,
    parameter logic [7:0]  END_CHAR  = 8'h24
) (
    input  logic           clk,
    input  logic           reset,
    lz77_decoder_if.slave  bus
);
    localparam logic [5:0] WIN_DEPTH_W = 6'(WIN_DEPTH);

    // State names describe what the registered outputs hold during the cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_LIT,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] hist_q [WIN_DEPTH];
    logic [3:0] hist_d [WIN_DEPTH];
    logic [4:0] offset_q, offset_d;
    logic [4:0] remain_q, remain_d;
    logic [7:0] char_q, char_d;
    logic       ready_q, ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_char_q, out_char_d;
    logic       finish_q, finish_d;

    logic       accept;
    logic [4:0] rd_off;
    logic [3:0] rd_sym;
    logic       shift_en;
    logic [3:0] shift_sym;
    logic       lit_go;
    logic [7:0] lit_char;

`ifdef LZ77_DEC_ERR_EN
    logic [5:0] fill_q, fill_d;
    logic       err_q, err_d;
`endif

    assign accept = bus.valid && bus.encode && ready_q;

    // The first copied symbol is read with the live offset so it can be
    // registered on the accept edge; later symbols use the latched offset.
    always_comb begin
        rd_off = (state_q == S_IDLE) ? bus.offset : offset_q;
        rd_sym = '0;
        for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
            if (5'(i) == rd_off) begin
                rd_sym = hist_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        remain_d    = remain_q;
        char_d      = char_q;
        out_valid_d = 1'b0;
        out_char_d  = out_char_q;
        finish_d    = finish_q;
        shift_en    = 1'b0;
        shift_sym   = '0;
        lit_go      = 1'b0;
        lit_char    = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    offset_d = bus.offset;
                    char_d   = bus.char_nxt;
                    if (bus.match_len != '0) begin
                        shift_en    = 1'b1;
                        shift_sym   = rd_sym;
                        out_valid_d = 1'b1;
                        out_char_d  = {4'h0, rd_sym};
                        remain_d    = bus.match_len - 5'd1;
                        state_d     = S_COPY;
                    end else begin
                        lit_go   = 1'b1;
                        lit_char = bus.char_nxt;
                    end
                end
            end
            S_COPY: begin
                if (remain_q != '0) begin
                    shift_en    = 1'b1;
                    shift_sym   = rd_sym;
                    out_valid_d = 1'b1;
                    out_char_d  = {4'h0, rd_sym};
                    remain_d    = remain_q - 5'd1;
                end else begin
                    lit_go   = 1'b1;
                    lit_char = char_q;
                end
            end
            S_LIT: begin
                state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The end marker produces no character and leaves history untouched.
        if (lit_go) begin
            if (lit_char != END_CHAR) begin
                shift_en    = 1'b1;
                shift_sym   = lit_char[3:0];
                out_valid_d = 1'b1;
                out_char_d  = lit_char;
                state_d     = S_LIT;
            end else begin
                finish_d = 1'b1;
                state_d  = S_DONE;
            end
        end

        ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d[0] = shift_sym;
            for (int unsigned i = 1; i < WIN_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

`ifdef LZ77_DEC_ERR_EN
    always_comb begin
        fill_d = fill_q;
        err_d  = err_q;
        if (shift_en && (fill_q < WIN_DEPTH_W)) begin
            fill_d = fill_q + 6'd1;
        end
        if (accept && (({1'b0, bus.offset} >= WIN_DEPTH_W) ||
                       ((bus.match_len != '0) && ({1'b0, bus.offset} >= fill_q)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hist_q      <= '{default: '0};
            offset_q    <= '0;
            remain_q    <= '0;
            char_q      <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            offset_q    <= offset_d;
            remain_q    <= remain_d;
            char_q      <= char_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            finish_q    <= finish_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.finish    = finish_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder with hand-computed expected character streams.
module tb_lz77_decoder;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    byte unsigned expq[$];

    lz77_decoder_if bus();

    lz77_decoder #(.WIN_DEPTH(30), .END_CHAR(8'h24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_ready"}, bus.ready, 8'h01);
        chk({tag, "_ov"}, bus.out_valid, 8'h00);
        chk({tag, "_oc"}, bus.out_char, 8'h00);
        chk({tag, "_fin"}, bus.finish, 8'h00);
`ifdef LZ77_DEC_ERR_EN
        chk({tag, "_err"}, bus.err, 8'h00);
`endif
    endtask

    task automatic drive(input logic [4:0] off, input logic [4:0] len, input logic [7:0] ch);
        bus.valid     = 1'b1;
        bus.encode    = 1'b1;
        bus.offset    = off;
        bus.match_len = len;
        bus.char_nxt  = ch;
    endtask

    task automatic idle_inputs();
        bus.valid  = 1'b0;
        bus.encode = 1'b0;
    endtask

    // Sends one token and checks len+1 output cycles against expq, then ready return.
    task automatic run_tok(input string tag, input logic [4:0] off, input logic [4:0] len,
                           input logic [7:0] ch);
        chk({tag, "_rdy_pre"}, bus.ready, 8'h01);
        drive(off, len, ch);
        step();
        idle_inputs();
        for (int i = 0; i <= int'(len); i++) begin
            chk({tag, "_ov"}, bus.out_valid, 8'h01);
            chk({tag, "_oc"}, bus.out_char, expq[i]);
            chk({tag, "_rdy_busy"}, bus.ready, 8'h00);
            step();
        end
        chk({tag, "_rdy_back"}, bus.ready, 8'h01);
        chk({tag, "_ov_idle"}, bus.out_valid, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.encode = 1'b0;
        bus.offset = '0;
        bus.match_len = '0;
        bus.char_nxt = '0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            reset_chk("idle");
            step();
        end

        expq = '{8'h05};
        run_tok("lit05", 5'd0, 5'd0, 8'h05);
        expq = '{8'h09};
        run_tok("lit09", 5'd0, 5'd0, 8'h09);

        // valid without encode must not be taken
        bus.valid = 1'b1;
        bus.encode = 1'b0;
        bus.char_nxt = 8'h0B;
        step();
        chk("noenc_ov", bus.out_valid, 8'h00);
        chk("noenc_rdy", bus.ready, 8'h01);
        step();
        chk("noenc_ov2", bus.out_valid, 8'h00);
        idle_inputs();

        expq = '{8'h01};
        run_tok("lit01", 5'd0, 5'd0, 8'h01);
        expq = '{8'h02};
        run_tok("lit02", 5'd0, 5'd0, 8'h02);
        expq = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h03};
        run_tok("ovl", 5'd1, 5'd5, 8'h03);

        expq = '{8'h07};
        run_tok("lit07", 5'd0, 5'd0, 8'h07);
        expq.delete();
        for (int i = 0; i < 25; i++) expq.push_back(8'h07);
        run_tok("maxlen", 5'd0, 5'd24, 8'h07);

        // history now: [0..25]=7, [26]=3, [27]=1, [28]=2, [29]=1
        expq = '{8'h01, 8'h02};
        run_tok("off29", 5'd29, 5'd1, 8'h02);
`ifdef LZ77_DEC_ERR_EN
        chk("off29_err", bus.err, 8'h00);
`endif
        expq = '{8'h00, 8'h02};
        run_tok("off30", 5'd30, 5'd1, 8'h02);
`ifdef LZ77_DEC_ERR_EN
        chk("off30_err", bus.err, 8'h01);
`endif

        expq = '{8'h04};
        run_tok("lit04", 5'd0, 5'd0, 8'h04);
        expq = '{8'h05};
        run_tok("lit05b", 5'd0, 5'd0, 8'h05);
        expq = '{8'h06};
        run_tok("lit06", 5'd0, 5'd0, 8'h06);

        chk("end_rdy_pre", bus.ready, 8'h01);
        drive(5'd2, 5'd3, 8'h24);
        step();
        idle_inputs();
        expq = '{8'h04, 8'h05, 8'h06};
        for (int i = 0; i < 3; i++) begin
            chk("end_ov", bus.out_valid, 8'h01);
            chk("end_oc", bus.out_char, expq[i]);
            chk("end_fin_early", bus.finish, 8'h00);
            step();
        end
        chk("end_fin", bus.finish, 8'h01);
        chk("end_ov_none", bus.out_valid, 8'h00);
        chk("end_rdy", bus.ready, 8'h00);
        drive(5'd0, 5'd0, 8'h0B);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_ov", bus.out_valid, 8'h00);
            chk("done_fin", bus.finish, 8'h01);
            chk("done_rdy", bus.ready, 8'h00);
        end
        idle_inputs();

        reset = 1'b1;
        step();
        reset = 1'b0;
        reset_chk("rst_done");

        // token offered on the reset edge is dropped
        reset = 1'b1;
        drive(5'd0, 5'd0, 8'h0C);
        step();
        reset = 1'b0;
        idle_inputs();
        reset_chk("rst_tok");
        step();
        reset_chk("rst_tok2");

        chk("mid_rdy_pre", bus.ready, 8'h01);
        drive(5'd0, 5'd10, 8'h0E);
        step();
        idle_inputs();
        chk("mid_ov1", bus.out_valid, 8'h01);
        step();
        chk("mid_ov2", bus.out_valid, 8'h01);
        step();
        chk("mid_ov3", bus.out_valid, 8'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        reset_chk("rst_mid");
        step();
        reset_chk("rst_mid2");

        expq = '{8'h0A};
        run_tok("lit0a", 5'd0, 5'd0, 8'h0A);
        expq = '{8'h0A, 8'h01};
        run_tok("cp1", 5'd0, 5'd1, 8'h01);
`ifdef LZ77_DEC_ERR_EN
        chk("err_before", bus.err, 8'h00);
        expq = '{8'h00, 8'h00, 8'h00};
        run_tok("errtok", 5'd5, 5'd2, 8'h00);
        chk("err_after", bus.err, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
